// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline register scoreboard producing load-use stall and forwarding selects.
//   Optional build macro SCOREBOARD_STATS_EN adds stall/forward event counters.
//   Ports:
//     clk, reset            clock and synchronous active-high reset
//     issue_valid/wr/wa/ld  instruction in decode asking to advance to E
//     rd_valid, rd_addr     decode read ports (NRD ports, TW bits each)
//     flush                 branch taken in E; kills decode and the instruction in E
//     stall_d               combinational hold of fetch/decode
//     fwd_sel               registered per-port forward source for the instruction in E (0 = regfile)
//     busy_mask             registers with an in-flight writer
//     stall_cnt, fwd_cnt    saturating event counters (SCOREBOARD_STATS_EN only)
module hazard_scoreboard #(
   parameter int NREG   = 16,
   parameter int DEPTH  = 3,
   parameter int NRD    = 3,
   parameter int LD_LAT = 2,
   parameter int PC_REG = 15,
   localparam int TW    = $clog2(NREG),
   localparam int FW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic              issue_wr,
   input  logic [TW-1:0]     issue_wa,
   input  logic              issue_ld,
   input  logic [NRD-1:0]    rd_valid,
   input  logic [NRD*TW-1:0] rd_addr,
   input  logic              flush,
   output logic              stall_d,
   output logic [NRD*FW-1:0] fwd_sel,
   output logic [NREG-1:0]   busy_mask
`ifdef SCOREBOARD_STATS_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       fwd_cnt
`endif
);
   logic [DEPTH:1]    r_v;
   logic [DEPTH:1]    r_ld;
   logic [TW-1:0]     r_wa [1:DEPTH];
   logic [NRD*FW-1:0] r_fwd;
   logic              w_ld_hit;
   logic              w_accept;
   logic [NRD*FW-1:0] w_fwd;
   logic [NREG-1:0]   w_busy;

   // Walk entries oldest to youngest so the youngest matching writer overwrites the select.
   always_comb begin
      w_ld_hit = 1'b0;
      w_fwd    = '0;
      w_busy   = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (r_v[k]) w_busy[r_wa[k]] = 1'b1;
         for (int i = 0; i < NRD; i++)
            if (rd_valid[i] && r_v[k] && r_wa[k] == rd_addr[i*TW +: TW] && rd_addr[i*TW +: TW] != TW'(PC_REG)) begin
               // the oldest entry is written back this cycle, so the register file already sees it
               if (k < DEPTH) w_fwd[i*FW +: FW] = FW'(k);
               if (k < LD_LAT && r_ld[k]) w_ld_hit = 1'b1;
            end
      end
   end

   assign stall_d   = ~flush & issue_valid & w_ld_hit;
   assign w_accept  = issue_valid & ~stall_d & ~flush;
   assign fwd_sel   = r_fwd;
   assign busy_mask = w_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_v   <= '0;
         r_ld  <= '0;
         r_wa  <= '{default: '0};
         r_fwd <= '0;
      end else begin
         r_v[1]  <= w_accept & issue_wr;
         r_ld[1] <= issue_ld;
         r_wa[1] <= issue_wa;
         for (int k = 2; k <= DEPTH; k++) begin
            // a flush kills the instruction leaving E
            r_v[k]  <= (k == 2 && flush) ? 1'b0 : r_v[k-1];
            r_ld[k] <= r_ld[k-1];
            r_wa[k] <= r_wa[k-1];
         end
         r_fwd <= w_accept ? w_fwd : '0;
      end
   end

`ifdef SCOREBOARD_STATS_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_fwd_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
         r_fwd_cnt   <= '0;
      end else begin
         if (stall_d && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 32'd1;
         if ((|r_fwd) && !(&r_fwd_cnt)) r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign fwd_cnt   = r_fwd_cnt;
`endif
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 16: number of architectural registers; TW = $clog2(NREG).
REQ-002 Parameter DEPTH, default 3: in-flight stages tracked after decode (E, M, W); FW = $clog2(DEPTH).
REQ-003 Parameter NRD, default 3: decode read ports (Rn, Rm, Rs).
REQ-004 Parameter LD_LAT, default 2: first entry index from which a load result can be forwarded.
REQ-005 Parameter PC_REG, default 15: register index that is never forwarded or stalled on.
REQ-006 clk  input  1  single clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 issue_valid  input  1  decode instruction requests advance to E.
REQ-009 issue_wr  input  1  issuing instruction writes a register.
REQ-010 issue_wa  input  TW  destination register.
REQ-011 issue_ld  input  1  issuing instruction is a load.
REQ-012 rd_valid  input  NRD  per-port read enable.
REQ-013 rd_addr  input  NRD*TW  per-port source register.
REQ-014 flush  input  1  branch taken in E; kill decode and entry 1.
REQ-015 stall_d  output  1  hold fetch/decode this cycle (combinational).
REQ-016 fwd_sel  output  NRD*FW  registered per-port forward source for the instruction now in E; 0 = register file.
REQ-017 busy_mask  output  NREG  bit r set while any valid entry writes r.

Function
REQ-018 Tracking shift register of DEPTH entries {valid, wa, ld}, shifting by one every cycle; entry k holds the instruction k cycles past decode; entry DEPTH drops out.
REQ-019 Entry 1 loads {issue_valid & issue_wr & ~stall_d & ~flush, issue_wa, issue_ld}; otherwise it loads a bubble (valid=0).
REQ-020 flush forces entry 2 invalid on the next shift (kills the instruction leaving entry 1) and forces stall_d=0; flush dominates stall.
REQ-021 Port i matches entry k when rd_valid[i], entry k valid, wa == rd_addr[i] and rd_addr[i] != PC_REG.
REQ-022 stall_d = ~flush & issue_valid & (any port matches an entry k < LD_LAT with ld=1).
REQ-023 On each cycle with issue accepted, fwd_sel[i] registers the smallest k in 1..DEPTH-1 with a match (youngest writer wins); 0 when no match; matches at entry DEPTH yield 0 (register-file write-through).
REQ-024 When no issue is accepted (stall, flush or ~issue_valid), fwd_sel registers 0.
REQ-025 Encoding: fwd_sel value k selects the result k stages beyond E (1 = ALUOutM, 2 = ResultW).
REQ-026 busy_mask is combinational from entries 1..DEPTH.

Reset
REQ-027 On reset all entries invalid, fwd_sel = 0, counters = 0; hence stall_d = 0 and busy_mask = 0 in the following cycle.
REQ-028 Reset asserted mid-operation discards all in-flight entries in one cycle; no partial shift.

Configuration
REQ-029 Macro SCOREBOARD_STATS_EN: when defined, add outputs stall_cnt and fwd_cnt (32 bits each). stall_cnt increments on each cycle with stall_d=1. fwd_cnt increments by one on each cycle where any registered fwd_sel port is nonzero. Both counters saturate at all-ones and clear on reset.
REQ-030 Without SCOREBOARD_STATS_EN, neither port nor counter logic exists.

Verification (NREG=16, DEPTH=3, LD_LAT=2)
REQ-031 Issue ADD writing r1, then a reader of r1 on port 0 the next cycle -> stall_d=0; fwd_sel[0]=1 one cycle later.
REQ-032 Issue LDR writing r2, then an immediate reader of r2 -> stall_d=1 for exactly one cycle, then issue accepted with fwd_sel=2.
REQ-033 Consecutive writes to r3 (two ADDs), then a reader of r3 -> fwd_sel=1 (youngest writer wins).
REQ-034 Load-use on r4 with flush asserted in the same cycle -> stall_d=0; entry 2 invalid the next cycle; busy_mask[4] clears.
REQ-035 Reader of r15 while r15 is in flight -> stall_d=0, fwd_sel=0.
REQ-036 Reset asserted with 3 valid entries -> busy_mask=0 and fwd_sel=0 the next cycle; with SCOREBOARD_STATS_EN, the counters read 0.
